// File: rtl/pixel_fetch_if.sv
// Pixel fetch bus bundle: SRAM read port plus
// the downstream pixel stream handshake.
interface pixel_fetch_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 8
);
    logic                 mem_start;
    logic                 mem_writemode;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_rdata;
    logic                 mem_done;
    logic                 pix_valid;
    logic [DATA_BITS-1:0] pix_data;
    logic                 pix_ready;

    modport master (
        output mem_start,
        output mem_writemode,
        output mem_addr,
        input  mem_rdata,
        input  mem_done,
        output pix_valid,
        output pix_data,
        input  pix_ready
    );

    modport slave (
        input  mem_start,
        input  mem_writemode,
        input  mem_addr,
        output mem_rdata,
        output mem_done,
        input  pix_valid,
        input  pix_data,
        output pix_ready
    );
endinterface

// File: rtl/pixel_fetch.sv
// Frame pixel fetcher: one outstanding SRAM read at a time,
// results buffered in a small FIFO toward the pixel consumer.
module pixel_fetch #(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_frame,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS-1:0] num_pixels,
    pixel_fetch_if.master        bus,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_BITS-1:0] A_ONE = 1;
    localparam logic [PW-1:0] P_ONE = 1;
    localparam logic [PW:0] C_ONE = 1;
    localparam logic [PW:0] C_FULL = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

    state_t state_q, state_d;

    logic [ADDR_BITS-1:0] addr_q;
    logic [ADDR_BITS-1:0] idx_q;
    logic [ADDR_BITS-1:0] num_q;
    logic                 done_q;

    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW:0]          count;

    logic empty, full, last, push, pop, take;

    assign empty = (count == '0);
    assign full  = (count == C_FULL);
    assign last  = (idx_q == num_q - A_ONE);
    assign push  = (state_q == WAIT) && bus.mem_done;
    assign pop   = !empty && bus.pix_ready;
    assign take  = (state_q == IDLE) && start_frame;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start_frame && num_pixels != '0) state_d = ISSUE;
            ISSUE: if (!full) state_d = WAIT;
            WAIT:  if (bus.mem_done) state_d = last ? DRAIN : ISSUE;
            DRAIN: if (empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_start     = (state_q == ISSUE) && !full;
        bus.mem_writemode = 1'b0;
        bus.mem_addr      = addr_q;
        bus.pix_valid     = !empty;
        bus.pix_data      = fifo_mem[rd_ptr];
        busy              = (state_q != IDLE);
        frame_done        = done_q;
    end

    // addr_q tracks base+index so the address is already registered at issue
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            idx_q  <= '0;
            num_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (take && num_pixels == '0) ||
                      (state_q == DRAIN && empty);
            if (take) begin
                addr_q <= base_addr;
                num_q  <= num_pixels;
                idx_q  <= '0;
            end else if (push) begin
                addr_q <= addr_q + A_ONE;
                idx_q  <= idx_q + A_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + P_ONE;
            if (pop)  rd_ptr <= rd_ptr + P_ONE;
            if (push && !pop)      count <= count + C_ONE;
            else if (pop && !push) count <= count - C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_pixel_fetch.sv
// Scoreboard bench for pixel_fetch with a fixed-latency
// SRAM model returning the address low byte.
module tb_pixel_fetch;
    localparam int AB  = 16;
    localparam int DB  = 8;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_frame = 1'b0;
    logic [AB-1:0] base_addr = '0;
    logic [AB-1:0] num_pixels = '0;
    logic          busy;
    logic          frame_done;

    pixel_fetch_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    pixel_fetch #(
        .ADDR_BITS(AB),
        .DATA_BITS(DB),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_frame(start_frame),
        .base_addr(base_addr),
        .num_pixels(num_pixels),
        .bus(bus),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errs   = 0;
    int starts = 0;
    int frames = 0;

    logic [AB-1:0] exp_addr[$];
    logic [DB-1:0] exp_pix[$];

    bit            pend = 1'b0;
    int            cnt  = 0;
    logic [AB-1:0] paddr = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SRAM model: completes each read LAT cycles after the strobe
    always @(negedge clk) begin
        bus.mem_done = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                bus.mem_done  = 1'b1;
                bus.mem_rdata = paddr[DB-1:0];
                pend = 1'b0;
            end
        end
        if (bus.mem_start && !rst) begin
            pend  = 1'b1;
            cnt   = LAT;
            paddr = bus.mem_addr;
        end
    end

    // Monitor: pops expectations whenever the DUT presents output
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_start) begin
                starts++;
                if (exp_addr.size() == 0) chk("mem_addr_unexpected", 1, 0);
                else chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
            end
            if (bus.pix_valid && bus.pix_ready) begin
                if (exp_pix.size() == 0) chk("pix_unexpected", 1, 0);
                else chk("pix_data", 32'(bus.pix_data), 32'(exp_pix.pop_front()));
            end
            if (frame_done) frames++;
        end
    end

    task automatic expect_frame(input logic [AB-1:0] b, input int n);
        logic [AB-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = b + AB'(i);
            exp_addr.push_back(a);
            exp_pix.push_back(a[DB-1:0]);
        end
    endtask

    task automatic start(input logic [AB-1:0] b, input logic [AB-1:0] n);
        @(posedge clk); #1;
        start_frame = 1'b1;
        base_addr   = b;
        num_pixels  = n;
        @(posedge clk); #1;
        start_frame = 1'b0;
    endtask

    task automatic wait_frame(input string name, input int f0);
        int n = 0;
        while (frames == f0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (frames == f0) chk({name, "_timeout"}, 0, 1);
        @(negedge clk);
        chk({name, "_busy_after"}, 32'(busy), 0);
        chk({name, "_done_pulse"}, 32'(frame_done), 0);
        chk({name, "_q_empty"}, exp_pix.size(), 0);
    endtask

    initial begin
        int f0, s0, n;
        bus.pix_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pix_valid", 32'(bus.pix_valid), 0);
        chk("rst_mem_start", 32'(bus.mem_start), 0);
        chk("rst_writemode", 32'(bus.mem_writemode), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // basic three-pixel frame
        bus.pix_ready = 1'b1;
        f0 = frames;
        expect_frame(16'h0100, 3);
        start(16'h0100, 16'd3);
        wait_frame("basic", f0);
        chk("basic_frames", frames - f0, 1);

        // backpressure fills the FIFO and stalls issue
        bus.pix_ready = 1'b0;
        f0 = frames;
        s0 = starts;
        expect_frame(16'h0200, 8);
        start(16'h0200, 16'd8);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("bp_starts_stall", starts - s0, 4);
        chk("bp_busy", 32'(busy), 1);
        chk("bp_valid", 32'(bus.pix_valid), 1);
        @(posedge clk); #1;
        bus.pix_ready = 1'b1;
        wait_frame("bp", f0);
        chk("bp_starts_total", starts - s0, 8);

        // address wrap
        f0 = frames;
        expect_frame(16'hFFFE, 4);
        start(16'hFFFE, 16'd4);
        wait_frame("wrap", f0);

        // zero-length frame
        f0 = frames;
        s0 = starts;
        @(posedge clk); #1;
        start_frame = 1'b1;
        base_addr   = 16'h1234;
        num_pixels  = 16'd0;
        @(negedge clk);
        chk("zero_done_early", 32'(frame_done), 0);
        @(posedge clk); #1;
        start_frame = 1'b0;
        @(negedge clk);
        chk("zero_done", 32'(frame_done), 1);
        chk("zero_busy", 32'(busy), 0);
        @(negedge clk);
        chk("zero_done_fall", 32'(frame_done), 0);
        repeat (4) @(negedge clk);
        chk("zero_no_start", starts - s0, 0);
        chk("zero_frames", frames - f0, 1);

        // reset during WAIT of second pixel, late mem_done afterwards
        s0 = starts;
        expect_frame(16'h0300, 5);
        start(16'h0300, 16'd5);
        n = 0;
        while (starts - s0 < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (starts - s0 < 2) chk("abort_timeout", 0, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_addr.delete();
        exp_pix.delete();
        f0 = frames;
        s0 = starts;
        repeat (8) @(negedge clk);
        chk("abort_valid", 32'(bus.pix_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_no_done", frames - f0, 0);
        chk("abort_no_start", starts - s0, 0);
        expect_frame(16'h0010, 2);
        start(16'h0010, 16'd2);
        wait_frame("after_abort", f0);
        chk("after_abort_frames", frames - f0, 1);

        // start_frame while busy is ignored
        f0 = frames;
        s0 = starts;
        expect_frame(16'h0040, 3);
        start(16'h0040, 16'd3);
        repeat (2) @(posedge clk);
        #1;
        start_frame = 1'b1;
        base_addr   = 16'h0080;
        num_pixels  = 16'd6;
        @(posedge clk); #1;
        start_frame = 1'b0;
        wait_frame("ignore", f0);
        repeat (10) @(negedge clk);
        chk("ignore_starts", starts - s0, 3);
        chk("ignore_frames", frames - f0, 1);
        chk("ignore_busy", 32'(busy), 0);
        chk("final_addr_q", exp_addr.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pixel_fetch.md
PIXEL_FETCH -- requirements
Module: pixel_fetch

Interface
REQ-001 Parameter ADDR_BITS, default 16, SRAM word-address width.
REQ-002 Parameter DATA_BITS, default 8, pixel width.
REQ-003 Parameter FIFO_DEPTH, default 4, output buffer entries, power of two, at least 2.
REQ-004 clk  in  1  single clock; reset is synchronous and active-high; all state changes on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start_frame  in  1  one-cycle request to fetch a frame.
REQ-007 base_addr  in  ADDR_BITS  first pixel address, sampled with start_frame.
REQ-008 num_pixels  in  ADDR_BITS  pixel count, sampled with start_frame.
REQ-009 mem_start  out  1  one-cycle transaction strobe to SRAM interface.
REQ-010 mem_writemode  out  1  constant 0 (read).
REQ-011 mem_addr  out  ADDR_BITS  registered read address.
REQ-012 mem_rdata  in  DATA_BITS  read data from SRAM interface.
REQ-013 mem_done  in  1  transaction complete; mem_rdata valid this cycle.
REQ-014 pix_valid  out  1  pix_data holds a pixel.
REQ-015 pix_data  out  DATA_BITS  FIFO head.
REQ-016 pix_ready  in  1  downstream accepts; pop when pix_valid & pix_ready.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 frame_done  out  1  one-cycle pulse at frame completion.

Function
REQ-019 States SHALL be IDLE, ISSUE, WAIT, DRAIN.
REQ-020 IDLE: start_frame with num_pixels!=0 SHALL latch base_addr, num_pixels, clear index to 0, go to ISSUE.
REQ-021 IDLE: start_frame with num_pixels==0 SHALL pulse frame_done next cycle and stay IDLE.
REQ-022 start_frame outside IDLE SHALL be ignored.
REQ-023 ISSUE: if FIFO occupancy < FIFO_DEPTH, SHALL assert mem_start for exactly one cycle with mem_addr = base+index (mod 2^ADDR_BITS) and go to WAIT; otherwise SHALL stall in ISSUE with mem_start=0.
REQ-024 mem_addr SHALL remain stable from the mem_start cycle until the mem_done cycle inclusive.
REQ-025 mem_done SHALL be honoured only in WAIT; ignored in all other states.
REQ-026 WAIT on mem_done: push mem_rdata into FIFO, index+1; if index was num_pixels-1 go to DRAIN, else ISSUE.
REQ-027 At most one SRAM transaction SHALL be outstanding.
REQ-028 DRAIN: when FIFO empty (including pop making it empty this cycle, visible next cycle) SHALL pulse frame_done and go to IDLE.
REQ-029 FIFO SHALL preserve order; simultaneous push and pop SHALL keep occupancy unchanged; push never occurs when full (guaranteed by REQ-023).
REQ-030 pix_valid SHALL equal FIFO not-empty; pix_data SHALL be stable while pix_valid & !pix_ready.
REQ-031 Pop with FIFO empty SHALL have no effect.
REQ-032 Index and address arithmetic SHALL wrap modulo 2^ADDR_BITS; num_pixels up to 2^ADDR_BITS-1 supported.
REQ-033 Minimum throughput SHALL be one pixel per (SRAM latency + 1) cycles when pix_ready held high.

Reset
REQ-034 rst SHALL force state IDLE, FIFO empty, index 0, mem_start=0, mem_writemode=0, mem_addr=0, pix_valid=0, busy=0, frame_done=0.
REQ-035 rst asserted mid-frame SHALL abort immediately; FIFO contents discarded; no frame_done pulse; a late mem_done after reset SHALL be ignored.

Verification
REQ-036 base=0x0100, num=3, pix_ready=1, SRAM returns addr low byte after 3 cycles -> mem_addr 0x0100,0x0101,0x0102; pix_data 0x00,0x01,0x02; one frame_done; busy low after.
REQ-037 num=8, pix_ready=0 -> exactly 4 mem_start pulses then stall in ISSUE; raise pix_ready -> remaining 4 fetched, 8 pixels in order.
REQ-038 base=0xFFFE, num=4 -> addresses 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-039 num=0 start_frame -> no mem_start, frame_done one cycle later, busy stays 0.
REQ-040 rst during WAIT of pixel 2 of 5, mem_done arrives after reset -> pix_valid=0, no push, no frame_done; new start_frame runs cleanly.
REQ-041 start_frame pulsed while busy -> ignored; original frame completes with original count.
